// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard and the
// register-index decoder that feeds it.
package hazard_pkg;

  // Slots carry RV32 register indices.
  localparam int SLOT_REG_W = 5;

  // Opcodes shared with the decoder.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] src1;
    logic [SLOT_REG_W-1:0] src2;
    logic [SLOT_REG_W-1:0] dest;
    logic                  is_load;
  } ex_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] dest;
    logic                  is_load;
  } mem_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] dest;
  } wb_slot_t;

  // A slot writes r when it is valid, targets r, and r is not x0.
  function automatic logic slot_writes(input logic                  valid,
                                       input logic [SLOT_REG_W-1:0] dest,
                                       input logic [SLOT_REG_W-1:0] r);
    return valid && (dest == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one EX operand: picks MEM over WB, else the
// register file. x0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [SLOT_REG_W-1:0] i_src,
  input  mem_slot_t             i_mem,
  input  wb_slot_t              i_wb,
  output fwd_sel_e              o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = slot_writes(i_mem.valid, i_mem.dest, i_src);
  assign w_wb_hit  = slot_writes(i_wb.valid, i_wb.dest, i_src);

  // Youngest producer wins.
  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding control for the 5-stage pipeline. Shadows the
// EX/MEM/WB occupants and derives stall, forwarding selects and a
// saturating stall counter.
// Build option HAZARD_SCOREBOARD_FORWARD_EN: when defined, forwarding is
// enabled and only load-use stalls; otherwise selects are tied to the
// register file and any EX/MEM producer of an ID source stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall_out,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  ex_slot_t         r_ex;
  mem_slot_t        r_mem;
  wb_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [SLOT_REG_W-1:0] w_src1;
  logic [SLOT_REG_W-1:0] w_src2;
  logic [SLOT_REG_W-1:0] w_dest;
  logic                  w_ex_hit;
  logic                  w_stall;
  fwd_sel_e              w_sel_a;
  fwd_sel_e              w_sel_b;

  assign w_src1 = SLOT_REG_W'(id_src1);
  assign w_src2 = SLOT_REG_W'(id_src2);
  assign w_dest = SLOT_REG_W'(id_dest);

  assign w_ex_hit = slot_writes(r_ex.valid, r_ex.dest, w_src1) |
                    slot_writes(r_ex.valid, r_ex.dest, w_src2);

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
  // Everything but a load result can be forwarded in time.
  assign w_stall = id_valid & ~flush & r_ex.is_load & w_ex_hit;
`else
  logic w_mem_hit;
  assign w_mem_hit = slot_writes(r_mem.valid, r_mem.dest, w_src1) |
                     slot_writes(r_mem.valid, r_mem.dest, w_src2);
  // Without forwarding, wait until the producer reaches WB.
  assign w_stall = id_valid & ~flush & (w_ex_hit | w_mem_hit);
`endif

  fwd_select u_fwd_a (
    .i_src (r_ex.src1),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_sel_a)
  );

  fwd_select u_fwd_b (
    .i_src (r_ex.src2),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_sel_b)
  );

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
  assign fwd_a = w_sel_a;
  assign fwd_b = w_sel_b;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  assign stall_out    = w_stall;
  assign stall_cycles = r_stall_cnt;

  // Advance the shadow pipeline; a bubble is fully zeroed so it never matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= '{valid: r_mem.valid, dest: r_mem.dest};
      r_mem <= '{valid: r_ex.valid, dest: r_ex.dest, is_load: r_ex.is_load};
      if (flush || w_stall || !id_valid) begin
        r_ex <= '0;
      end else begin
        r_ex <= '{valid: 1'b1, src1: w_src1, src2: w_src2,
                  dest: w_dest, is_load: id_is_load};
      end
    end
  end

  // Count stalled cycles, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // The load-use stall keeps a MEM-stage load from ever being a forward source.
  a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_mem.is_load && ((w_sel_a == FWD_MEM) || (w_sel_b == FWD_MEM))));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the build
// option HAZARD_SCOREBOARD_FORWARD_EN.
module tb_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int CNT_W = 8;   // small counter so saturation is reachable quickly
  localparam int SAT_N = (1 << CNT_W) + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [REG_W-1:0] id_src1, id_src2, id_dest;
  logic             id_is_load;
  logic             flush;
  logic             stall_out;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_dest      (id_dest),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall_out    (stall_out),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic             v;
    logic [REG_W-1:0] s1, s2, d;
    logic             ld, fl;
    logic             stall;
    logic [1:0]       fa, fb;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void row(input int v, s1, s2, d, ld, fl, st, fa, fb, cnt);
    vec_t r;
    r.v = 1'(v);    r.s1 = 5'(s1); r.s2 = 5'(s2); r.d = 5'(d);
    r.ld = 1'(ld);  r.fl = 1'(fl); r.stall = 1'(st);
    r.fa = 2'(fa);  r.fb = 2'(fb); r.cnt = CNT_W'(cnt);
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v, s1, s2, d, ld, fl);
    id_valid = 1'(v); id_src1 = 5'(s1); id_src2 = 5'(s2);
    id_dest = 5'(d);  id_is_load = 1'(ld); flush = 1'(fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("reset stall", stall_out, 0);
    chk("reset fwd_a", fwd_a, 0);
    chk("reset fwd_b", fwd_b, 0);
    chk("reset cnt", stall_cycles, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset released");

    //  v s1 s2 d ld fl | stall fa fb cnt
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    row(1,1,2,5,0,0, 0,0,0,0);  // add x5,x1,x2
    row(1,5,3,6,0,0, 0,0,0,0);  // add x6,x5,x3
    row(0,0,0,0,0,0, 0,1,0,0);  // add6 in EX, add5 in MEM
    row(1,1,2,5,0,0, 0,0,0,0);
    row(0,0,0,0,0,0, 0,0,0,0);
    row(1,5,3,6,0,0, 0,0,0,0);
    row(0,0,0,0,0,0, 0,2,0,0);  // one nop gap -> WB
    row(1,1,2,5,0,0, 0,0,0,0);
    row(0,0,0,0,0,0, 0,0,0,0);
    row(0,0,0,0,0,0, 0,0,0,0);
    row(1,5,3,6,0,0, 0,0,0,0);
    row(0,0,0,0,0,0, 0,0,0,0);  // two nop gap -> RF
    row(1,1,0,5,1,0, 0,0,0,0);  // lw x5,0(x1)
    row(1,5,5,7,0,0, 1,0,0,0);  // add x7,x5,x5 load-use
    row(1,5,5,7,0,0, 0,0,0,1);  // held, bubble in EX
    row(0,0,0,0,0,0, 0,2,2,1);  // add7 in EX, lw in WB
    row(1,0,0,0,0,0, 0,0,0,1);  // addi x0,x0,1
    row(1,0,0,1,0,0, 0,0,0,1);  // add x1,x0,x0
    row(1,0,0,1,0,0, 0,0,0,1);  // jal x1
    row(1,0,0,0,0,0, 0,0,0,1);  // sw, src fields 0
    row(0,0,0,0,0,0, 0,0,0,1);
    row(1,1,0,5,1,0, 0,0,0,1);  // lw x5
    row(1,5,5,7,0,1, 0,0,0,1);  // load-use with flush
    row(1,5,0,8,0,0, 0,0,0,1);  // EX bubble, lw in MEM
    row(0,0,0,0,0,0, 0,2,0,1);
    row(1,1,2,5,0,0, 0,0,0,1);  // add x5
    row(1,3,4,5,0,0, 0,0,0,1);  // add x5 again
    row(1,5,5,6,0,0, 0,0,0,1);
    row(0,0,0,0,0,0, 0,1,1,1);  // MEM beats WB
`else
    row(1,1,2,5,0,0, 0,0,0,0);  // add x5,x1,x2
    row(1,5,3,6,0,0, 1,0,0,0);  // add x6,x5,x3: EX producer
    row(1,5,3,6,0,0, 1,0,0,1);  // MEM producer
    row(1,5,3,6,0,0, 0,0,0,2);
    row(0,0,0,0,0,0, 0,0,0,2);
    row(0,0,0,0,0,0, 0,0,0,2);
    row(0,0,0,0,0,0, 0,0,0,2);
    row(1,1,2,5,0,0, 0,0,0,2);
    row(0,0,0,0,0,0, 0,0,0,2);
    row(1,5,3,6,0,0, 1,0,0,2);  // one nop gap: one stall
    row(1,5,3,6,0,0, 0,0,0,3);
    row(0,0,0,0,0,0, 0,0,0,3);
    row(1,1,2,5,0,0, 0,0,0,3);
    row(0,0,0,0,0,0, 0,0,0,3);
    row(0,0,0,0,0,0, 0,0,0,3);
    row(1,5,3,6,0,0, 0,0,0,3);  // two nop gap: none
    row(1,1,0,5,1,0, 0,0,0,3);  // lw x5
    row(1,5,5,7,0,0, 1,0,0,3);
    row(1,5,5,7,0,0, 1,0,0,4);
    row(1,5,5,7,0,0, 0,0,0,5);
    row(0,0,0,0,0,0, 0,0,0,5);
    row(1,0,0,0,0,0, 0,0,0,5);  // addi x0,x0,1
    row(1,0,0,1,0,0, 0,0,0,5);  // add x1,x0,x0
    row(1,0,0,1,0,0, 0,0,0,5);  // jal x1
    row(1,0,0,0,0,0, 0,0,0,5);  // sw, src fields 0
    row(0,0,0,0,0,0, 0,0,0,5);
    row(1,1,0,5,1,0, 0,0,0,5);  // lw x5
    row(1,5,5,7,0,1, 0,0,0,5);  // hazard with flush
    row(1,5,0,8,0,0, 1,0,0,5);  // lw advanced to MEM
    row(1,5,0,8,0,0, 0,0,0,6);
    row(0,0,0,0,0,0, 0,0,0,6);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].ld, vecs[i].fl);
      @(negedge clk);
      $display("vec %0d: stall=%0d fa=%0d fb=%0d cnt=%0d", i, stall_out, fwd_a, fwd_b, stall_cycles);
      chk($sformatf("vec%0d stall", i), stall_out, vecs[i].stall);
      chk($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].fa);
      chk($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].fb);
      chk($sformatf("vec%0d cnt", i), stall_cycles, vecs[i].cnt);
      @(posedge clk);
      #1;
    end

    // Mid-run reset with a load-use hazard pending.
    drive(1, 1, 0, 5, 1, 0);
    @(posedge clk); #1;
    drive(1, 5, 5, 7, 0, 0);
    @(negedge clk);
    chk("pre-reset stall", stall_out, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset stall", stall_out, 0);
    chk("midreset fwd_a", fwd_a, 0);
    chk("midreset fwd_b", fwd_b, 0);
    chk("midreset cnt", stall_cycles, 0);
    $display("mid-run reset: stall=%0d cnt=%0d", stall_out, stall_cycles);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postreset stall", stall_out, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("postreset fwd_a", fwd_a, 0);
    chk("postreset fwd_b", fwd_b, 0);
    chk("postreset cnt", stall_cycles, 0);
    $display("post-reset add7 in EX: fa=%0d fb=%0d", fwd_a, fwd_b);
    @(posedge clk); #1;

    // Saturation: a self-dependent load repeated stalls every other cycle or more.
    drive(1, 5, 0, 5, 1, 0);
    n = 0;
    cyc = 0;
    while (n < SAT_N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stall_out) begin
        n++;
        if (n == 200) chk("sat cnt@200", stall_cycles, 199);
        if (n == 256) chk("sat cnt@256", stall_cycles, 255);
      end
    end
    chk("sat budget", n, SAT_N);
    @(posedge clk); #1;
    chk("sat cnt final", stall_cycles, (1 << CNT_W) - 1);
    $display("saturation: %0d stall cycles, cnt=%0h", n, stall_cycles);
    drive(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
